// File: rtl/cdc_xfer_scheduler_pkg.sv
// cdc_xfer_scheduler_pkg
// Shared definitions for the source-side transfer scheduler and the
// destination-side receiver: FSM state encoding and the default hold length.
// No ports.
package cdc_xfer_scheduler_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } xfer_state_e;

   // Default number of source cycles a word stays stable on the crossing path.
   localparam int unsigned DEFAULT_HOLD_CYCLES = 8;

endpackage

// File: rtl/cdc_xfer_scheduler_rr_arbiter.sv
// cdc_xfer_scheduler_rr_arbiter
// Combinational round-robin pick. Scans REQ starting at ptr+1 and wrapping
// modulo NUM_REQ; the first set bit wins.
// Ports:
//   req  - per-requester request
//   ptr  - index of the last winner (search starts one above it)
//   gnt  - one-hot winner (all zero when no request)
//   idx  - binary index of the winner (zero when no request)
module cdc_xfer_scheduler_rr_arbiter #(
   parameter int unsigned  NUM_REQ   = 4,
   localparam int unsigned PTR_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [PTR_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [PTR_WIDTH-1:0] idx
);

   logic                 found;
   logic [PTR_WIDTH-1:0] cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      // Offset NUM_REQ lands back on ptr itself, so the last winner has lowest priority.
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = PTR_WIDTH'((32'(ptr) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/cdc_xfer_scheduler.sv
// cdc_xfer_scheduler
// Source-domain scheduler sharing one multi-bit CDC path among NUM_REQ
// requesters. A round-robin winner's word is captured and then held, along with
// its requester ID and a new-word toggle, for HOLD_CYCLES cycles so the
// destination double-flop stage only ever samples settled data.
// Ports:
//   CLK         - source clock, rising edge
//   RESET_N     - synchronous active-low reset
//   ENABLE      - 1 allows new grants
//   REQ         - per-requester level request
//   REQ_DATA    - requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   GNT         - combinational one-hot grant; transfer when REQ[i] & GNT[i]
//   BUSY        - registered, high while a word is held
//   XFER_DATA   - registered word into the crossing stage
//   XFER_ID     - registered owner index of XFER_DATA
//   XFER_TOGGLE - registered, inverts on every captured word
module cdc_xfer_scheduler
   import cdc_xfer_scheduler_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ID_WIDTH    = 2,
   parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic                          ENABLE,
   input  logic [NUM_REQ-1:0]            REQ,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
   output logic [NUM_REQ-1:0]            GNT,
   output logic                          BUSY,
   output logic [DATA_WIDTH-1:0]         XFER_DATA,
   output logic [ID_WIDTH-1:0]           XFER_ID,
   output logic                          XFER_TOGGLE
);

   localparam int unsigned PTR_WIDTH = $clog2(NUM_REQ);
   localparam int unsigned CNT_WIDTH = $clog2(HOLD_CYCLES + 1);

   xfer_state_e           state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [PTR_WIDTH-1:0]  ptr_q, ptr_d;
   logic                  busy_q, busy_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic                  tog_q, tog_d;

   logic [NUM_REQ-1:0]    arb_gnt;
   logic [PTR_WIDTH-1:0]  arb_idx;
   logic [NUM_REQ-1:0]    gnt_int;

   cdc_xfer_scheduler_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req (REQ),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      data_d  = data_q;
      id_d    = id_q;
      tog_d   = tog_q;
      gnt_int = '0;
      unique case (state_q)
         IDLE: begin
            if (ENABLE) begin
               gnt_int = arb_gnt;
               // Grant is derived from REQ, so a dropped REQ simply yields no transfer.
               if (|(REQ & arb_gnt)) begin
                  state_d = HOLD;
                  cnt_d   = CNT_WIDTH'(HOLD_CYCLES - 1);
                  busy_d  = 1'b1;
                  data_d  = REQ_DATA[32'(arb_idx) * DATA_WIDTH +: DATA_WIDTH];
                  id_d    = ID_WIDTH'(arb_idx);
                  tog_d   = ~tog_q;
                  ptr_d   = arb_idx;
               end
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset is synchronous, so the grant must be masked explicitly while it is held.
   assign GNT         = RESET_N ? gnt_int : '0;
   assign BUSY        = busy_q;
   assign XFER_DATA   = data_q;
   assign XFER_ID     = id_q;
   assign XFER_TOGGLE = tog_q;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= PTR_WIDTH'(NUM_REQ - 1);
         busy_q  <= 1'b0;
         data_q  <= '0;
         id_q    <= '0;
         tog_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         data_q  <= data_d;
         id_q    <= id_d;
         tog_q   <= tog_d;
      end
   end

endmodule

// File: tb/tb_cdc_xfer_scheduler.sv
// tb_cdc_xfer_scheduler
// Directed stimulus pushes expected grants into a scoreboard queue; a monitor
// on the falling edge pops an entry whenever GNT is asserted and checks the
// grant, the grant spacing, the captured outputs and the hold length.
module tb_cdc_xfer_scheduler;

   localparam int unsigned NREQ = 4;
   localparam int unsigned DW   = 32;
   localparam int unsigned IDW  = 2;
   localparam int unsigned HOLD = 8;

   typedef struct {
      int          id;
      logic [31:0] data;
      logic        tog;
      int          gap;   // expected cycles since previous grant, 0 = unchecked
   } exp_t;

   logic                 CLK;
   logic                 RESET_N;
   logic                 ENABLE;
   logic [NREQ-1:0]      REQ;
   logic [NREQ*DW-1:0]   REQ_DATA;
   logic [NREQ-1:0]      GNT;
   logic                 BUSY;
   logic [DW-1:0]        XFER_DATA;
   logic [IDW-1:0]       XFER_ID;
   logic                 XFER_TOGGLE;

   logic [31:0] data_tab [NREQ];
   exp_t        exp_q [$];
   logic        exp_tog;
   int          checks;
   int          errors;

   // Monitor state
   int   cyc;
   int   last_gnt_cyc;
   int   busy_run;
   bit   arm;
   bit   hold_active;
   exp_t cur;

   cdc_xfer_scheduler #(
      .NUM_REQ     (NREQ),
      .DATA_WIDTH  (DW),
      .ID_WIDTH    (IDW),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .ENABLE      (ENABLE),
      .REQ         (REQ),
      .REQ_DATA    (REQ_DATA),
      .GNT         (GNT),
      .BUSY        (BUSY),
      .XFER_DATA   (XFER_DATA),
      .XFER_ID     (XFER_ID),
      .XFER_TOGGLE (XFER_TOGGLE)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input int id, input int gap);
      exp_t e;
      exp_tog = ~exp_tog;
      e.id    = id;
      e.data  = data_tab[id];
      e.tog   = exp_tog;
      e.gap   = gap;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      RESET_N = 1'b0;
      REQ     = '0;
      ENABLE  = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      exp_tog = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Scoreboard monitor
   always @(negedge CLK) begin
      cyc++;
      if (!RESET_N) begin
         busy_run    = 0;
         arm         = 1'b0;
         hold_active = 1'b0;
      end else begin
         if (arm) begin
            arm         = 1'b0;
            hold_active = 1'b1;
            chk("busy_after_capture", 32'(BUSY), 32'd1);
         end
         if (hold_active) begin
            if (BUSY) begin
               chk("xfer_id", 32'(XFER_ID), 32'(cur.id));
               chk("xfer_data", XFER_DATA, cur.data);
               chk("xfer_toggle", 32'(XFER_TOGGLE), 32'(cur.tog));
               chk("gnt_zero_in_hold", 32'(GNT), 32'd0);
            end else begin
               hold_active = 1'b0;
            end
         end
         if (BUSY) begin
            busy_run++;
         end else if (busy_run != 0) begin
            chk("hold_length", 32'(busy_run), 32'(HOLD));
            busy_run = 0;
         end
         if (GNT != '0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_grant actual=%b required=none (t=%0t)", GNT, $time);
            end else begin
               cur = exp_q.pop_front();
               chk("grant_onehot", 32'(GNT), 32'd1 << cur.id);
               if (cur.gap != 0) chk("grant_spacing", 32'(cyc - last_gnt_cyc), 32'(cur.gap));
               arm = 1'b1;
            end
            last_gnt_cyc = cyc;
         end
      end
   end

   initial begin
      checks       = 0;
      errors       = 0;
      cyc          = 0;
      last_gnt_cyc = 0;
      busy_run     = 0;
      arm          = 1'b0;
      hold_active  = 1'b0;
      exp_tog      = 1'b0;
      data_tab[0]  = 32'h1111_0000;
      data_tab[1]  = 32'h2222_0001;
      data_tab[2]  = 32'hDEAD_BEEF;
      data_tab[3]  = 32'h4444_0003;
      for (int i = 0; i < int'(NREQ); i++) REQ_DATA[i*DW +: DW] = data_tab[i];

      // Reset held with all requests high: nothing granted, outputs cleared.
      RESET_N = 1'b0;
      ENABLE  = 1'b1;
      REQ     = 4'b1111;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_gnt", 32'(GNT), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_data", XFER_DATA, 32'd0);
      chk("rst_id", 32'(XFER_ID), 32'd0);
      chk("rst_toggle", 32'(XFER_TOGGLE), 32'd0);
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      exp_tog = 1'b0;
      push_exp(0, 0);                  // requester 0 has first priority
      idle_cycles(1);
      REQ = '0;
      idle_cycles(10);

      // Single word from requester 2; REQ stays high through the hold.
      do_reset();
      REQ = 4'b0100;
      push_exp(2, 0);
      idle_cycles(1);
      idle_cycles(8);
      REQ = '0;
      idle_cycles(4);

      // Round-robin with all requests held: 0,1,2,3 every 9 cycles.
      do_reset();
      push_exp(0, 0);
      push_exp(1, 9);
      push_exp(2, 9);
      push_exp(3, 9);
      REQ = 4'b1111;
      idle_cycles(36);
      REQ = '0;
      idle_cycles(10);

      // ENABLE dropped mid-hold: hold completes, no grant until re-enabled.
      do_reset();
      REQ = 4'b0010;
      push_exp(1, 0);
      idle_cycles(1);
      REQ = '0;
      idle_cycles(3);
      ENABLE = 1'b0;
      REQ    = 4'b1111;
      idle_cycles(15);
      push_exp(2, 0);                  // pointer was 1
      ENABLE = 1'b1;
      idle_cycles(1);
      REQ = '0;
      idle_cycles(10);

      // Reset at hold cycle 3: everything clears, pointer restarts at 0.
      do_reset();
      REQ = 4'b0100;
      push_exp(2, 0);
      idle_cycles(1);
      REQ = '0;
      idle_cycles(2);
      RESET_N = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      chk("midrst_busy", 32'(BUSY), 32'd0);
      chk("midrst_data", XFER_DATA, 32'd0);
      chk("midrst_id", 32'(XFER_ID), 32'd0);
      chk("midrst_toggle", 32'(XFER_TOGGLE), 32'd0);
      chk("midrst_gnt", 32'(GNT), 32'd0);
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      exp_tog = 1'b0;
      REQ     = 4'b1111;
      push_exp(0, 0);
      idle_cycles(1);
      REQ = '0;
      idle_cycles(10);

      // Wrap/skip: after a grant to 3, REQ=1001 alternates 0,3,0.
      do_reset();
      REQ = 4'b1000;
      push_exp(3, 0);
      push_exp(0, 9);
      push_exp(3, 9);
      push_exp(0, 9);
      idle_cycles(1);
      REQ = 4'b1001;
      idle_cycles(27);
      REQ = '0;
      idle_cycles(12);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
